// File: rtl/pwm_gen.sv
// rtl/pwm_gen.sv - PWM stage driving an external flexible up-counter
//
// Purpose: sequences the counter (enable/clear/wrap) through IDLE/RUN/DRAIN
// and turns its count/at_max into a registered PWM waveform plus a
// per-period strobe. Duty updates arrive over a valid/ready handshake and
// are double-buffered so they only take effect at period boundaries.
//
// Ports:
//   clk, nrst     clock (rising edge), synchronous active-low reset
//   run           level; 1 = generate PWM, 0 = stop at end of current period
//   polarity      0 = active-high pwm_out, 1 = active-low pwm_out
//   duty_in       requested high-time in counts (0..2^N), N+1 bits
//   duty_valid    duty_in valid
//   duty_ready    block can accept duty_in
//   count         counter count
//   at_max        counter at_max
//   cnt_enable    counter enable
//   cnt_clear     counter clear
//   cnt_wrap      counter wrap (tied high)
//   pwm_out       registered PWM output
//   period_done   one-cycle pulse per completed period

module pwm_gen #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         nrst,
   input  logic         run,
   input  logic         polarity,
   input  logic [N:0]   duty_in,
   input  logic         duty_valid,
   output logic         duty_ready,
   input  logic [N-1:0] count,
   input  logic         at_max,
   output logic         cnt_enable,
   output logic         cnt_clear,
   output logic         cnt_wrap,
   output logic         pwm_out,
   output logic         period_done
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   state_t     state_q;
   state_t     state_d;
   logic [N:0] duty_active;
   logic [N:0] duty_shadow;
   logic       pending;
   logic       boundary;
   logic       active_now;

   assign cnt_wrap   = 1'b1;
   assign duty_ready = !pending;

   // Last count of a period while the counter is live.
   assign boundary   = (state_q != IDLE) && at_max;

   // Duty is one bit wider than count so duty = 2^N keeps the output
   // active for every count value.
   assign active_now = (state_q != IDLE) && ({1'b0, count} < duty_active);

   always_comb begin
      state_d    = state_q;
      cnt_enable = 1'b0;
      cnt_clear  = 1'b1;
      case (state_q)
         IDLE: begin
            if (run) begin
               state_d = RUN;
            end
         end
         RUN: begin
            cnt_enable = 1'b1;
            cnt_clear  = 1'b0;
            if (!run) begin
               state_d = at_max ? IDLE : DRAIN;
            end
         end
         DRAIN: begin
            // A stop request always lets the period in progress finish;
            // reasserting run before at_max resumes without a gap.
            cnt_enable = 1'b1;
            cnt_clear  = 1'b0;
            if (at_max) begin
               state_d = IDLE;
            end else if (run) begin
               state_d = RUN;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         state_q     <= IDLE;
         duty_active <= '0;
         duty_shadow <= '0;
         pending     <= 1'b0;
         pwm_out     <= 1'b0;
         period_done <= 1'b0;
      end else begin
         state_q <= state_d;
         // Accept and apply are mutually exclusive: accept needs pending=0,
         // apply needs pending=1.
         if (duty_valid && !pending) begin
            duty_shadow <= duty_in;
            pending     <= 1'b1;
         end else if (pending && ((state_q == IDLE) || boundary)) begin
            duty_active <= duty_shadow;
            pending     <= 1'b0;
         end
         pwm_out     <= polarity ^ active_now;
         period_done <= boundary;
      end
   end

endmodule

// File: tb/tb_pwm_gen.sv
// tb/tb_pwm_gen.sv - self-checking bench for pwm_gen with a behavioural counter
module tb_pwm_gen;

   localparam int N = 4;

   logic         clk = 1'b0;
   logic         nrst;
   logic         run;
   logic         polarity;
   logic [N:0]   duty_in;
   logic         duty_valid;
   logic         duty_ready;
   logic [N-1:0] count;
   logic [N-1:0] max_val;
   logic         at_max;
   logic         cnt_enable;
   logic         cnt_clear;
   logic         cnt_wrap;
   logic         pwm_out;
   logic         period_done;

   always #5 clk = ~clk;

   pwm_gen #(.N(N)) dut (
      .clk         (clk),
      .nrst        (nrst),
      .run         (run),
      .polarity    (polarity),
      .duty_in     (duty_in),
      .duty_valid  (duty_valid),
      .duty_ready  (duty_ready),
      .count       (count),
      .at_max      (at_max),
      .cnt_enable  (cnt_enable),
      .cnt_clear   (cnt_clear),
      .cnt_wrap    (cnt_wrap),
      .pwm_out     (pwm_out),
      .period_done (period_done)
   );

   // The flexible up-counter the block is wrapped around.
   always_ff @(posedge clk) begin
      if (!nrst)
         count <= '0;
      else if (cnt_clear)
         count <= '0;
      else if (cnt_enable) begin
         if (count == max_val)
            count <= cnt_wrap ? '0 : count;
         else
            count <= count + 1'b1;
      end
   end
   assign at_max = (count == max_val);

   int total = 0;
   int bad   = 0;
   bit chk_on = 0;

   // Reference model: "on" = counter live, "stop" = stop requested,
   // duty as plain integers.
   bit m_on, m_stop, m_pending, m_pwm, m_pd;
   int m_cnt, m_active, m_shadow;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_check();
      chk("model_pwm_out", pwm_out, m_pwm);
      chk("model_period_done", period_done, m_pd);
      chk("model_duty_ready", duty_ready, !m_pending);
      chk("model_cnt_enable", cnt_enable, m_on);
      chk("model_cnt_clear", cnt_clear, !m_on);
      chk("model_cnt_wrap", cnt_wrap, 1);
      chk("model_count", count, m_cnt);
   endtask

   task automatic tick();
      bit end_p, pre_rst;
      bit n_on, n_stop, n_pend, n_pwm, n_pd;
      int n_cnt, n_act, n_sh;
      pre_rst = !nrst;
      end_p   = m_on && (m_cnt == int'(max_val));
      if (pre_rst) begin
         n_on = 0; n_stop = 0; n_pend = 0; n_pwm = 0; n_pd = 0;
         n_cnt = 0; n_act = 0; n_sh = 0;
      end else begin
         n_pwm  = polarity ^ (m_on && (m_cnt < m_active));
         n_pd   = end_p;
         n_act  = m_active;
         n_sh   = m_shadow;
         n_pend = m_pending;
         if (duty_valid && !m_pending) begin
            n_sh   = int'(duty_in);
            n_pend = 1;
         end else if (m_pending && (!m_on || end_p)) begin
            n_act  = m_shadow;
            n_pend = 0;
         end
         n_cnt = (m_on && !end_p) ? m_cnt + 1 : 0;
         if (!m_on) begin
            n_on = run; n_stop = 0;
         end else if (end_p) begin
            n_on = run && !m_stop; n_stop = 0;
         end else begin
            n_on = 1; n_stop = !run;
         end
      end
      @(posedge clk);
      #1;
      m_on = n_on; m_stop = n_stop; m_pending = n_pend; m_pwm = n_pwm; m_pd = n_pd;
      m_cnt = n_cnt; m_active = n_act; m_shadow = n_sh;
      if (pre_rst) chk_on = 1;
      if (chk_on) model_check();
   endtask

   task automatic do_reset();
      nrst = 0; run = 0; duty_valid = 0; duty_in = '0;
      tick();
      tick();
      nrst = 1;
   endtask

   task automatic write_duty(input int d);
      duty_in = d[N:0];
      duty_valid = 1;
      tick();
      duty_valid = 0;
   endtask

   task automatic wait_count(input int c, input string name);
      int n = 0;
      while (count !== c[N-1:0] && n < 100) begin
         tick();
         n++;
      end
      chk(name, count, c);
   endtask

   typedef struct {
      int duty;
      bit pol;
      int maxv;
      int exp_high;
      int exp_idle;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   initial begin
      int highs, pds;
      int h[3];
      int exp_seq[4];

      vecs[0] = '{duty: 3,  pol: 0, maxv: 9,  exp_high: 3,  exp_idle: 0};
      vecs[1] = '{duty: 0,  pol: 0, maxv: 9,  exp_high: 0,  exp_idle: 0};
      vecs[2] = '{duty: 10, pol: 0, maxv: 9,  exp_high: 10, exp_idle: 0};
      vecs[3] = '{duty: 3,  pol: 1, maxv: 9,  exp_high: 3,  exp_idle: 1};
      vecs[4] = '{duty: 7,  pol: 0, maxv: 9,  exp_high: 7,  exp_idle: 0};
      vecs[5] = '{duty: 16, pol: 0, maxv: 15, exp_high: 16, exp_idle: 0};
      vecs[6] = '{duty: 12, pol: 1, maxv: 9,  exp_high: 10, exp_idle: 1};
      vecs[7] = '{duty: 1,  pol: 0, maxv: 4,  exp_high: 1,  exp_idle: 0};

      nrst = 0; run = 0; polarity = 0; duty_valid = 0; duty_in = '0; max_val = 4'd9;

      // Reset, then IDLE.
      do_reset();
      chk("rst_pwm_out", pwm_out, 0);
      chk("rst_duty_ready", duty_ready, 1);
      chk("rst_period_done", period_done, 0);
      for (int i = 0; i < 6; i++) begin
         tick();
         chk("idle_cnt_clear", cnt_clear, 1);
         chk("idle_cnt_enable", cnt_enable, 0);
         chk("idle_pwm_out", pwm_out, 0);
         chk("idle_duty_ready", duty_ready, 1);
         chk("idle_period_done", period_done, 0);
      end

      // Duty / polarity / period table.
      for (int r = 0; r < 8; r++) begin
         max_val  = vecs[r].maxv[N-1:0];
         polarity = vecs[r].pol;
         do_reset();
         tick();
         tick();
         chk("tbl_idle_level", pwm_out, vecs[r].exp_idle);
         write_duty(vecs[r].duty);
         tick();
         run = 1;
         tick();
         chk("tbl_first_count", count, 0);
         highs = 0;
         pds = 0;
         for (int k = 1; k <= 2 * (vecs[r].maxv + 1); k++) begin
            tick();
            if (pwm_out !== polarity) highs++;
            if (period_done === 1'b1) pds++;
         end
         chk("tbl_active_cycles", highs, 2 * vecs[r].exp_high);
         chk("tbl_period_done", pds, 2);
         run = 0;
      end

      // Double-buffered update with a stalled second write.
      polarity = 0; max_val = 4'd9;
      do_reset();
      write_duty(3);
      tick();
      run = 1;
      tick();
      h[0] = 0; h[1] = 0; h[2] = 0;
      for (int k = 1; k <= 30; k++) begin
         tick();
         if (pwm_out !== polarity) h[(k - 1) / 10]++;
         if (k == 4) begin
            chk("db_write_count", count, 4);
            duty_in = 5'd7; duty_valid = 1;
         end
         if (k == 5) begin
            chk("db_ready_low", duty_ready, 0);
            duty_in = 5'd2;
         end
         if (k > 5 && k < 10) chk("db_stall_ready", duty_ready, 0);
         if (k == 10) chk("db_ready_after_bnd", duty_ready, 1);
         if (k == 11) duty_valid = 0;
      end
      chk("db_period_old", h[0], 3);
      chk("db_period_new", h[1], 7);
      chk("db_period_held", h[2], 2);
      run = 0;

      // Graceful stop.
      do_reset();
      write_duty(3);
      tick();
      run = 1;
      tick();
      wait_count(5, "stop_reach5");
      run = 0;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("stop_count", count, (k == 4) ? 0 : 6 + k);
         chk("stop_period_done", period_done, (k == 4) ? 1 : 0);
      end
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("stop_idle_count", count, 0);
         chk("stop_idle_clear", cnt_clear, 1);
         chk("stop_idle_pwm", pwm_out, 0);
         chk("stop_idle_pd", period_done, 0);
      end

      // Stop cancelled at count 7.
      run = 1;
      tick();
      wait_count(5, "cancel_reach5");
      run = 0;
      wait_count(7, "cancel_reach7");
      run = 1;
      exp_seq[0] = 8; exp_seq[1] = 9; exp_seq[2] = 0; exp_seq[3] = 1;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("cancel_count", count, exp_seq[k]);
         chk("cancel_enable", cnt_enable, 1);
      end
      run = 0;

      // Reset mid-run with a pending duty.
      do_reset();
      write_duty(3);
      tick();
      run = 1;
      tick();
      wait_count(3, "mrst_reach3");
      write_duty(9);
      wait_count(6, "mrst_reach6");
      chk("mrst_pending", duty_ready, 0);
      nrst = 0;
      tick();
      nrst = 1;
      chk("mrst_pwm_out", pwm_out, 0);
      chk("mrst_period_done", period_done, 0);
      chk("mrst_duty_ready", duty_ready, 1);
      chk("mrst_cnt_clear", cnt_clear, 1);
      tick();
      tick();
      highs = 0;
      for (int k = 0; k < 10; k++) begin
         tick();
         if (pwm_out !== polarity) highs++;
      end
      chk("mrst_old_duty_zero", highs, 0);
      run = 0;

      // Randomized traffic against the model.
      max_val = 4'd9;
      do_reset();
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 19) == 0) run = !run;
         duty_valid = ($urandom_range(0, 3) == 0);
         duty_in = 5'($urandom_range(0, 16));
         if ($urandom_range(0, 49) == 0) polarity = !polarity;
         nrst = ($urandom_range(0, 599) != 0);
         if (!nrst) max_val = 4'($urandom_range(3, 15));
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
PWM stage wrapped around one instance of the team's flexible up-counter (N-bit count, at_max strobe, enable/clear/wrap controls).
- Drives the counter's enable/clear/wrap controls.
- Consumes count and at_max to produce a PWM waveform and a per-period strobe.
- Duty-cycle updates arrive over a valid/ready handshake. They are double-buffered so they apply only at period boundaries (glitch-free).
- Period length is set by the counter's max input, which the top level drives. This block never sees max directly.

Parameters:
N, 4, counter width; must equal the counter instance's N. Duty is N+1 bits so 100% is representable.

Ports:
clk  input  1  clock, rising edge
nrst  input  1  synchronous active-low reset
run  input  1  level; 1 = generate PWM, 0 = stop at end of current period
polarity  input  1  0 = active-high output, 1 = active-low output
duty_in  input  N+1  requested high-time in counts (0..2^N)
duty_valid  input  1  duty_in valid
duty_ready  output  1  block can accept duty_in
count  input  N  counter count
at_max  input  1  counter at_max
cnt_enable  output  1  to counter enable
cnt_clear  output  1  to counter clear
cnt_wrap  output  1  to counter wrap; constant 1
pwm_out  output  1  registered PWM output
period_done  output  1  one-cycle pulse per completed period

Behaviour:
- Reset (nrst=0 at posedge):
  - State IDLE; duty_active=0, duty_shadow=0, pending=0.
  - pwm_out=0, period_done=0.
  - duty_ready=1 on the first cycle after reset.
- Counter control is combinational from state:
  - IDLE: cnt_enable=0, cnt_clear=1.
  - RUN or DRAIN: cnt_enable=1, cnt_clear=0.
  - cnt_wrap=1 always.
- FSM (IDLE, RUN, DRAIN):
  - IDLE -> RUN when run=1. The counter is held at 0 in IDLE, so the first RUN cycle sees count=0.
  - RUN -> DRAIN when run=0 and at_max=0.
  - RUN -> IDLE when run=0 and at_max=1.
  - DRAIN -> IDLE on at_max=1 (period completes cleanly).
  - DRAIN -> RUN if run=1 again before at_max; the stop is cancelled and the count continues uninterrupted.
- Boundary: a cycle with state in {RUN, DRAIN} and at_max=1.
- Duty handshake:
  - duty_ready = !pending.
  - Transfer when duty_valid && duty_ready: duty_shadow <= duty_in, pending <= 1.
  - duty_valid with duty_ready=0 is not accepted; the source holds it.
- Duty apply:
  - If pending=1 and (state==IDLE or boundary): duty_active <= duty_shadow, pending <= 0.
  - duty_ready rises the following cycle.
  - A transfer and an apply can never occur on the same cycle, because a transfer needs pending=0.
- pwm_out, 1-cycle registered latency:
  - pwm_out <= polarity XOR ((state != IDLE) && ({1'b0,count} < duty_active)).
  - Duty 0 gives the output constantly inactive.
  - Duty >= max+1 gives the output constantly active while running.
  - In IDLE the output sits at the inactive level (= polarity) from the cycle after reset onward.
- period_done <= boundary (registered). It pulses one cycle after at_max is seen, including the final period when entering IDLE.
- A new duty applied at a boundary takes effect from count=0 of the next period. The period in progress always finishes with its old duty.
- Mid-operation reset: nrst=0 overrides everything at the next edge. pwm_out=0 and the pending duty is discarded.
- polarity may change at any time and takes effect on the next pwm_out register update; it has no effect on state.

Test Plan:
1. Reset, then IDLE:
   - Stimulus: reset, counter max=9, run=0, polarity=0.
   - Required: cnt_clear=1, cnt_enable=0, pwm_out=0, duty_ready=1, period_done never pulses.
2. Duty 3, 10-count period:
   - Stimulus: write duty 3 in IDLE (applied next cycle), then run=1.
   - Required: pwm_out high 3 cycles then low 7, repeating every 10 cycles, lagging count by 1.
   - Required: period_done pulses once per 10 cycles, one cycle after count=9.
3. Double-buffered update:
   - Stimulus: while running duty 3, write duty 7 at count=4.
   - Required: duty_ready=0 until the boundary; the current period keeps 3 high cycles and the next period has 7.
   - Stimulus: a second write attempted while duty_ready=0.
   - Required: it stalls (not accepted).
4. Graceful stop and cancel:
   - Stimulus: drop run at count=5.
   - Required: the counter continues to 9, one final period_done, then IDLE with count held 0 and pwm_out inactive.
   - Stimulus: repeat, but reassert run at count=7.
   - Required: no IDLE entry; count goes 8, 9, 0 uninterrupted.
5. Extremes and polarity:
   - Stimulus: duty 0.
   - Required: pwm_out constantly 0.
   - Stimulus: duty 10 with max=9.
   - Required: pwm_out constantly 1 while running.
   - Stimulus: polarity=1 with duty 3.
   - Required: the waveform from scenario 2 is inverted and the IDLE level is 1.
6. Reset mid-run:
   - Stimulus: nrst=0 at count=6 with a pending duty.
   - Required: next cycle state IDLE, pwm_out=0, period_done=0, duty_ready=1, old active duty 0.
